// File: rtl/mem_copy_pkg.sv
// Shared definitions for the mem_copy block: default widths and FSM state encoding.
package mem_copy_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 64;

  // Legacy encodings kept as constants so older code comparing raw state bits still lines up.
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_CAP  = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  typedef enum logic [2:0] {
    IDLE = S_IDLE,
    RD   = S_RD,
    CAP  = S_CAP,
    WR   = S_WR,
    DONE = S_DONE
  } state_t;

endpackage

// File: rtl/mem_copy_agu.sv
// Address generation for mem_copy: source/destination pointers and remaining word count.
module mem_copy_agu
  import mem_copy_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W-1:0] len,
  output logic [ADDR_W-1:0] src_ptr,
  output logic [ADDR_W-1:0] dst_ptr,
  output logic              last
);

  logic [ADDR_W-1:0] cnt_q;

  // Latch the copy window on load; advance both pointers (wrapping) and count down per written word.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_ptr <= '0;
      dst_ptr <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      src_ptr <= src;
      dst_ptr <= dst;
      cnt_q   <= len;
    end else if (step) begin
      src_ptr <= src_ptr + ADDR_W'(1);
      dst_ptr <= dst_ptr + ADDR_W'(1);
      cnt_q   <= cnt_q - ADDR_W'(1);
    end
  end

  // The word currently being written is the final one.
  always_comb begin
    last = (cnt_q == ADDR_W'(1));
  end

endmodule

// File: rtl/mem_copy.sv
// Word-by-word RAM copy engine: read, capture, write per word, then a one-cycle done pulse.
module mem_copy
  import mem_copy_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W-1:0] len,
  output logic              busy,
  output logic              done,
  output logic              m_cen,
  output logic              m_wen,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_din,
  input  logic [DATA_W-1:0] m_dout
);

  state_t            state_q;
  state_t            state_n;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic              last;
  logic              agu_load;
  logic              agu_step;

  assign agu_load = (state_q == IDLE) && start && (len != '0);
  assign agu_step = (state_q == WR);

  mem_copy_agu #(
    .ADDR_W(ADDR_W)
  ) u_agu (
    .clk    (clk),
    .rst    (rst),
    .load   (agu_load),
    .step   (agu_step),
    .src    (src),
    .dst    (dst),
    .len    (len),
    .src_ptr(src_ptr),
    .dst_ptr(dst_ptr),
    .last   (last)
  );

  // Next-state selection; start is only looked at in IDLE, so a pulse while busy is dropped.
  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_n = (len == '0) ? DONE : RD;
      end
      RD:      state_n = CAP;
      CAP:     state_n = WR;
      WR:      state_n = last ? DONE : RD;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State and read-data capture; reset wins over everything and aborts a copy in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
    end else begin
      state_q <= state_n;
      if (state_q == CAP) data_q <= m_dout;
    end
  end

  // Moore decode of the RAM port; address and data are forced to zero while the RAM is idle.
  always_comb begin
    busy   = (state_q != IDLE);
    done   = (state_q == DONE);
    m_cen  = 1'b0;
    m_wen  = 1'b0;
    m_addr = '0;
    m_din  = '0;
    if (state_q == RD) begin
      m_cen  = 1'b1;
      m_addr = src_ptr;
    end else if (state_q == WR) begin
      m_cen  = 1'b1;
      m_wen  = 1'b1;
      m_addr = dst_ptr;
      m_din  = data_q;
    end
  end

endmodule
